// File: rtl/req_ack_responder.sv
// Winner-side responder: accepts a tagged request, waits a fixed latency, then
// returns a one-cycle acknowledge carrying the updated per-client accumulator.
module req_ack_responder #(
  parameter int REQ_DATA_WIDTH = 8,
  parameter int ACK_DATA_WIDTH = 8,
  parameter int LATENCY        = 2   // legal range 0..15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      winner_req,
  input  logic [REQ_DATA_WIDTH:0]   winner_data_req,
  output logic                      winner_ack,
  output logic [ACK_DATA_WIDTH-1:0] winner_data_ack,
  output logic                      busy
);

  localparam int EXT_WIDTH = (REQ_DATA_WIDTH > ACK_DATA_WIDTH) ? REQ_DATA_WIDTH : ACK_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } state_t;

  state_t                    state, state_nxt;
  logic [3:0]                cnt, cnt_nxt;
  logic                      accept;
  logic                      tag_q;
  logic [REQ_DATA_WIDTH-1:0] pay_q;
  logic [ACK_DATA_WIDTH-1:0] acc [2];

  logic                      tag_sel;
  logic [REQ_DATA_WIDTH-1:0] pay_sel;
  logic [EXT_WIDTH-1:0]      pay_wide;
  logic [ACK_DATA_WIDTH-1:0] sum;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (winner_req) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY);
          state_nxt = (LATENCY > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACK;
      end
      ACK:     state_nxt = RELEASE;
      RELEASE: if (!winner_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency ACK follows IDLE directly, so the live request feeds the sum.
  always_comb begin
    tag_sel  = (state == IDLE) ? winner_data_req[REQ_DATA_WIDTH] : tag_q;
    pay_sel  = (state == IDLE) ? winner_data_req[REQ_DATA_WIDTH-1:0] : pay_q;
    pay_wide = EXT_WIDTH'(pay_sel);
    sum      = acc[tag_sel] + pay_wide[ACK_DATA_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      tag_q           <= 1'b0;
      pay_q           <= '0;
      // NOTE: the accumulator array is reset explicitly because its contents are
      // visible on the acknowledge bus; a two-entry array costs nothing to clear.
      acc[0]          <= '0;
      acc[1]          <= '0;
      winner_ack      <= 1'b0;
      winner_data_ack <= '0;
      busy            <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        tag_q <= winner_data_req[REQ_DATA_WIDTH];
        pay_q <= winner_data_req[REQ_DATA_WIDTH-1:0];
      end
      // Outputs are registered from the next state so they align with the FSM.
      winner_ack      <= (state_nxt == ACK);
      winner_data_ack <= (state_nxt == ACK) ? sum : '0;
      busy            <= (state_nxt != IDLE);
      if (state_nxt == ACK) acc[tag_sel] <= sum;
    end
  end

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=0 instance, each compared every
// cycle against a transaction-timeline model, plus directed literal checks.
module tb_req_ack_responder;

  localparam int RW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req  [2];
  logic [RW:0]   dreq [2];
  logic          ack  [2];
  logic [AW-1:0] dack [2];
  logic          busy [2];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  req_ack_responder #(.REQ_DATA_WIDTH(RW), .ACK_DATA_WIDTH(AW), .LATENCY(2)) u_lat2 (
    .clk             (clk),
    .rst             (rst),
    .winner_req      (req[0]),
    .winner_data_req (dreq[0]),
    .winner_ack      (ack[0]),
    .winner_data_ack (dack[0]),
    .busy            (busy[0])
  );

  req_ack_responder #(.REQ_DATA_WIDTH(RW), .ACK_DATA_WIDTH(AW), .LATENCY(0)) u_lat0 (
    .clk             (clk),
    .rst             (rst),
    .winner_req      (req[1]),
    .winner_data_req (dreq[1]),
    .winner_ack      (ack[1]),
    .winner_data_ack (dack[1]),
    .busy            (busy[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: a transaction accepted at cycle t acknowledges in cycle
  // t+1+L, and stays busy until the first cycle >= t+L+2 that sees req low.
  int            cyc = 0;
  bit            m_active [2];
  int            m_t      [2];
  bit            m_tag    [2];
  logic [AW-1:0] m_pay    [2];
  logic [AW-1:0] m_acc    [2][2];
  bit            e_ack    [2];
  logic [AW-1:0] e_data   [2];
  bit            e_busy   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_ack[i]  = 1'b0;
      e_data[i] = '0;
      if (rst) begin
        m_active[i] = 1'b0;
        m_acc[i][0] = '0;
        m_acc[i][1] = '0;
      end else if (!m_active[i]) begin
        if (req[i]) begin
          m_active[i] = 1'b1;
          m_t[i]      = cyc;
          m_tag[i]    = dreq[i][RW];
          m_pay[i]    = dreq[i][AW-1:0];
        end
      end else if (cyc >= m_t[i] + lat_of(i) + 2 && !req[i]) begin
        m_active[i] = 1'b0;
      end
      if (m_active[i] && cyc + 1 == m_t[i] + 1 + lat_of(i)) begin
        m_acc[i][m_tag[i]] = m_acc[i][m_tag[i]] + m_pay[i];
        e_ack[i]           = 1'b1;
        e_data[i]          = m_acc[i][m_tag[i]];
      end
      e_busy[i] = m_active[i];
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d ack", i),  32'(ack[i]),  32'(e_ack[i]));
        check($sformatf("u%0d data", i), 32'(dack[i]), 32'(e_data[i]));
        check($sformatf("u%0d busy", i), 32'(busy[i]), 32'(e_busy[i]));
      end
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset ack",  32'(ack[i]),  32'd0);
      check("reset data", 32'(dack[i]), 32'd0);
      check("reset busy", 32'(busy[i]), 32'd0);
    end
  endtask

  // Issue one transaction on instance i, holding req for `hold` cycles after ACK.
  task automatic txn(input int i, input bit tag, input logic [7:0] pay, input logic [7:0] exp,
                     input int hold, input bit scramble, input bit early_drop);
    int n;
    req[i]  = 1'b1;
    dreq[i] = {tag, pay};
    @(negedge clk);
    n = 1;
    if (scramble)   dreq[i] = {~tag, ~pay};
    if (early_drop) req[i]  = 1'b0;
    while (ack[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack latency", 32'(n), 32'(lat_of(i) + 1));
    check("ack data",    32'(dack[i]), 32'(exp));
    check("model data",  32'(e_data[i]), 32'(exp));
    repeat (hold) begin
      @(negedge clk);
      check("release ack low", 32'(ack[i]),  32'd0);
      check("release busy",    32'(busy[i]), 32'd1);
    end
    req[i] = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    req[0]  = 1'b0;
    req[1]  = 1'b0;
    dreq[0] = '0;
    dreq[1] = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset();

    // Client 0 accumulation, then client 1 independence.
    txn(0, 1'b0, 8'h05, 8'h05, 1, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h03, 8'h08, 1, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h10, 8'h10, 1, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h00, 8'h08, 1, 1'b0, 1'b0);

    // Client 1 wrap, client 0 unaffected.
    do_reset();
    txn(0, 1'b0, 8'h04, 8'h04, 1, 1'b0, 1'b0);
    txn(0, 1'b1, 8'hFF, 8'hFF, 1, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h02, 8'h01, 1, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h00, 8'h04, 1, 1'b0, 1'b0);

    // Req held 4 cycles past ACK, low for one cycle, then a new request.
    txn(0, 1'b0, 8'h01, 8'h05, 5, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h01, 8'h02, 1, 1'b0, 1'b0);

    // Reset in the second WAIT cycle discards the transaction.
    req[0]  = 1'b1;
    dreq[0] = {1'b0, 8'h07};
    repeat (2) @(negedge clk);
    check("busy in wait", 32'(busy[0]), 32'd1);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort ack",  32'(ack[0]),  32'd0);
    check("abort data", 32'(dack[0]), 32'd0);
    check("abort busy", 32'(busy[0]), 32'd0);
    txn(0, 1'b0, 8'h01, 8'h01, 1, 1'b0, 1'b0);

    // Request dropped during WAIT still completes; payload changes are ignored.
    txn(0, 1'b0, 8'h02, 8'h03, 1, 1'b1, 1'b1);

    // Zero-latency instance with payload scrambled after accept.
    txn(1, 1'b0, 8'h09, 8'h09, 1, 1'b1, 1'b0);
    txn(1, 1'b1, 8'h33, 8'h33, 1, 1'b1, 1'b0);
    txn(1, 1'b0, 8'h01, 8'h0A, 1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Synthesizable target for the winner side of the two-client arbitration path. It accepts the arbiter's `winner_req` and `winner_data_req` (client tag plus payload) and applies a fixed service latency. It then returns `winner_ack` with `winner_data_ack` and enforces return-to-zero of the request before it accepts the next transaction. Each client has its own accumulator, so the acknowledge data identifies which client was served and in what order.

## Interface
- `REQ_DATA_WIDTH`, default 8: request payload width. The request bus is `REQ_DATA_WIDTH+1` bits, with the MSB as the client tag.
- `ACK_DATA_WIDTH`, default 8: acknowledge data width and accumulator width.
- `LATENCY`, default 2: service wait cycles between accept and acknowledge. Legal range 0..15.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `winner_req` in 1: request from the arbiter, held high until acknowledged.
- `winner_data_req` in `REQ_DATA_WIDTH+1`: bit [`REQ_DATA_WIDTH`] is the client id (0/1). Bits [`REQ_DATA_WIDTH-1`:0] are the payload.
- `winner_ack` out 1: acknowledge, one-cycle pulse.
- `winner_data_ack` out `ACK_DATA_WIDTH`: response data. It is valid only while `winner_ack` = 1.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset: state is IDLE and the wait counter is 0. `acc0` = `acc1` = 0, `winner_ack` = 0, `winner_data_ack` = 0 and `busy` = 0.
- FSM states are IDLE, WAIT, ACK and RELEASE.
- IDLE:
  - If `winner_req` = 1, capture the tag and payload, load the counter with `LATENCY`, and go to WAIT if `LATENCY` > 0, otherwise go to ACK.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACK, giving exactly `LATENCY` cycles in WAIT.
- ACK (one cycle):
  - `winner_ack` = 1.
  - `acc[tag]` <= `acc[tag]` + payload, and `winner_data_ack` presents that new sum.
  - Go to RELEASE.
- RELEASE:
  - `winner_ack` = 0, and `winner_data_ack` returns to 0.
  - Stay while `winner_req` = 1, and go to IDLE on the first cycle `winner_req` = 0.
- Arithmetic:
  - The payload is zero-extended to `ACK_DATA_WIDTH` or truncated to its low `ACK_DATA_WIDTH` bits.
  - The sum wraps modulo 2^`ACK_DATA_WIDTH` with no saturation and no overflow flag.
- Only the captured tag and payload are used. Changes on `winner_data_req` after accept are ignored.
- Request dropped during WAIT (protocol violation): the transaction still completes and the ACK pulse is still issued. RELEASE then exits on its first cycle.
- Reset asserted in any state forces the reset values on the next edge. An in-flight transaction is discarded, with no ACK and no accumulator update. Reset has priority over all transitions.
- The accumulators are independent. A client 0 transaction never alters `acc1`, and a client 1 transaction never alters `acc0`.

## Timing
- Accept edge is at the end of cycle t, when IDLE sees `winner_req` = 1.
- `busy` = 1 from cycle t+1 until the cycle RELEASE sees `winner_req` = 0, inclusive.
- `winner_ack` is high in cycle t+1+`LATENCY` only. With the default `LATENCY` of 2, that is t+3.
- A compliant requester drops `winner_req` in cycle a+1, where a is the ACK cycle. RELEASE sees the drop and the FSM is IDLE in a+2. A new request asserted in a+2 is accepted at the end of a+2.
- Back-to-back throughput is therefore one transaction per `LATENCY`+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `LATENCY` = 2, client 0 payload 0x05 with req held: ACK exactly 3 cycles after accept with data 0x05, `busy` high through RELEASE, then ACK back to 0.
- A second client 0 request with payload 0x03 after return-to-zero returns 0x08. A client 1 request with payload 0x10 then returns 0x10, and `acc0` is still 0x08, verified by a further client 0 request with payload 0x00 returning 0x08.
- Client 1 payload 0xFF, then payload 0x02: ACK data 0xFF, then 0x01 (wrap). Client 0 is unaffected.
- Req held high for 4 cycles after ACK: no second ACK, and the FSM stays in RELEASE. Req low for 1 cycle, then high: accepted, with ACK at accept+3.
- Reset pulsed in the second WAIT cycle of a client 0 payload 0x07 transaction: no ACK, all outputs 0, and the next client 0 payload 0x01 returns 0x01.
- `LATENCY` = 0 instance: ACK in cycle t+1. Payload changed the cycle after accept: ACK data uses the captured payload.
